// File: rtl/pakin.sv
// Fragment receiver: reassembles NFRG fragments per packet, buffers whole packets in a
// FIFO and re-emits each one as a single parallel 4-phase message.
module pakin #(
  parameter int unsigned ASZ   = 6,
  parameter int unsigned DSZ   = 4,
  parameter int unsigned RSZ   = 4,
  parameter int unsigned PSZ   = 20,
  parameter int unsigned FSZ   = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic           i_clk,
  input  logic           reset,
  output logic           ready,
  input  logic [FSZ-1:0] rcv0_pakio,
  input  logic           rcv0_req,
  output logic           rcv0_ack,
  output logic [ASZ-1:0] snd0_src,
  output logic [ASZ-1:0] snd0_dst,
  output logic [DSZ-1:0] snd0_dat,
  output logic [RSZ-1:0] snd0_red,
  output logic           snd0_req,
  input  logic           snd0_ack
);

  localparam int unsigned NFRG = PSZ / FSZ;
  localparam int unsigned CW   = (NFRG > 1) ? $clog2(NFRG) : 1;
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW   = PW + 1;
  localparam int unsigned AW   = PSZ - FSZ;

  logic           ready_q;
  logic           ack_q, ack_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  asm_q, asm_d;
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [NW-1:0]  count_q, count_d;
  logic [PSZ-1:0] mem_q [DEPTH];
  logic [PSZ-1:0] out_q, out_d;
  logic           sreq_q, sreq_d;

  logic           full, empty, last, cap, push, pop, load;
  logic [PSZ-1:0] frame;

  always_comb begin
    full    = (count_q == NW'(DEPTH));
    empty   = (count_q == '0);
    last    = (cnt_q == CW'(NFRG - 1));
    frame   = {asm_q, rcv0_pakio};
    // Only the last fragment can stall: it must land in the FIFO on its capture edge.
    cap     = ready_q && rcv0_req && !ack_q && !(last && full);
    push    = cap && last;
    pop     = ready_q && sreq_q && snd0_ack;
    load    = ready_q && !empty && !sreq_q && !snd0_ack;

    ack_d   = ack_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    out_d   = out_q;
    sreq_d  = sreq_q;

    if (cap) begin
      ack_d = 1'b1;
      asm_d = frame[AW-1:0];
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end else if (ready_q && !rcv0_req && ack_q) begin
      ack_d = 1'b0;
    end

    if (push) head_d = head_q + 1'b1;
    if (pop)  tail_d = tail_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    if (load) begin
      out_d  = mem_q[tail_q];
      sreq_d = 1'b1;
    end else if (pop) begin
      sreq_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      asm_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
      sreq_q  <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      out_q   <= out_d;
      sreq_q  <= sreq_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge i_clk) begin
    if (!reset && push) mem_q[head_q] <= frame;
  end

  assign ready    = ready_q;
  assign rcv0_ack = ack_q;
  assign snd0_req = sreq_q;
  assign snd0_src = out_q[PSZ-1 -: ASZ];
  assign snd0_dst = out_q[PSZ-ASZ-1 -: ASZ];
  assign snd0_dat = out_q[RSZ +: DSZ];
  assign snd0_red = out_q[RSZ-1:0];

endmodule

// File: tb/tb_pakin.sv
// Scoreboard bench for pakin: expected packets queue at send time, a monitor checks
// each new message presented on snd0.
module tb_pakin;
  localparam int unsigned ASZ = 6, DSZ = 4, RSZ = 4, PSZ = 20, FSZ = 5, NFRG = 4;

  logic           i_clk = 1'b0;
  logic           reset = 1'b1;
  logic           ready;
  logic [FSZ-1:0] rcv0_pakio = '0;
  logic           rcv0_req = 1'b0;
  logic           rcv0_ack;
  logic [ASZ-1:0] snd0_src, snd0_dst;
  logic [DSZ-1:0] snd0_dat;
  logic [RSZ-1:0] snd0_red;
  logic           snd0_req;
  logic           snd0_ack = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [PSZ-1:0] exp_q [$];
  bit ack_en = 1'b0;
  bit fast   = 1'b0;

  pakin dut (
    .i_clk(i_clk), .reset(reset), .ready(ready),
    .rcv0_pakio(rcv0_pakio), .rcv0_req(rcv0_req), .rcv0_ack(rcv0_ack),
    .snd0_src(snd0_src), .snd0_dst(snd0_dst), .snd0_dat(snd0_dat), .snd0_red(snd0_red),
    .snd0_req(snd0_req), .snd0_ack(snd0_ack)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [PSZ-1:0] mk_pkt(input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
                                           input logic [DSZ-1:0] t, input logic [RSZ-1:0] r);
    return {s, d, t, r};
  endfunction

  function automatic logic [PSZ-1:0] rand_pkt(input logic [RSZ-1:0] r);
    return mk_pkt(ASZ'($urandom), ASZ'($urandom), DSZ'($urandom), r);
  endfunction

  function automatic logic [FSZ-1:0] frag_of(input logic [PSZ-1:0] p, input int i);
    return p[PSZ-1-i*FSZ -: FSZ];
  endfunction

  // Monitor: every rising snd0_req must match the oldest outstanding packet.
  initial begin
    logic prev;
    logic [PSZ-1:0] e;
    prev = 1'b0;
    forever begin
      @(negedge i_clk);
      if (reset) prev = 1'b0;
      else begin
        if (snd0_req && !prev) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pkt: got %0h expected none",
                     {snd0_src, snd0_dst, snd0_dat, snd0_red});
          end else begin
            e = exp_q.pop_front();
            check("pkt", 32'({snd0_src, snd0_dst, snd0_dat, snd0_red}), 32'(e));
          end
        end
        prev = snd0_req;
      end
    end
  end

  // Consumer: acks a presented message (randomly delayed unless fast) and releases on req low.
  initial begin
    forever begin
      @(negedge i_clk);
      if (!ack_en || reset) snd0_ack = 1'b0;
      else if (snd0_req) begin
        if (fast || $urandom_range(3) != 0) snd0_ack = 1'b1;
      end else snd0_ack = 1'b0;
    end
  end

  task automatic wait_ack(input logic lvl, input string name);
    int n;
    n = 0;
    while (rcv0_ack !== lvl && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    check(name, 32'(rcv0_ack), 32'(lvl));
  endtask

  task automatic send_frag(input logic [FSZ-1:0] f);
    @(negedge i_clk);
    rcv0_pakio = f;
    rcv0_req   = 1'b1;
    @(negedge i_clk);
    wait_ack(1'b1, "frag_ack_hi");
    rcv0_req = 1'b0;
    wait_ack(1'b0, "frag_ack_lo");
  endtask

  task automatic send_pkt(input logic [PSZ-1:0] p);
    exp_q.push_back(p);
    for (int i = 0; i < NFRG; i++) send_frag(frag_of(p, i));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || snd0_req) && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge i_clk);
    reset    = 1'b1;
    rcv0_req = 1'b0;
    exp_q.delete();
    repeat (cycles) @(negedge i_clk);
    reset = 1'b0;
    @(negedge i_clk);
  endtask

  initial begin
    logic [PSZ-1:0] p;
    int n;

    // 1: reset state and init cycle
    repeat (3) @(negedge i_clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rcv_ack", 32'(rcv0_ack), 32'd0);
    check("rst_snd_req", 32'(snd0_req), 32'd0);
    check("rst_fields", 32'({snd0_src, snd0_dst, snd0_dat, snd0_red}), 32'd0);
    reset = 1'b0;
    @(negedge i_clk);
    check("ready_after_release", 32'(ready), 32'd1);

    // 2: known packet, latency check with consumer paused
    p = mk_pkt(6'h2A, 6'h15, 4'h9, 4'h6);
    check("frag_split", 32'({frag_of(p, 0), frag_of(p, 1), frag_of(p, 2), frag_of(p, 3)}),
          32'({5'h15, 5'h05, 5'h0C, 5'h16}));
    exp_q.push_back(p);
    for (int i = 0; i < NFRG - 1; i++) send_frag(frag_of(p, i));
    @(negedge i_clk);
    rcv0_pakio = frag_of(p, NFRG - 1);
    rcv0_req   = 1'b1;
    @(negedge i_clk);
    check("last_captured", 32'(rcv0_ack), 32'd1);
    check("req_not_yet", 32'(snd0_req), 32'd0);
    @(negedge i_clk);
    check("req_latency", 32'(snd0_req), 32'd1);
    check("src", 32'(snd0_src), 32'h2A);
    check("dst", 32'(snd0_dst), 32'h15);
    check("dat", 32'(snd0_dat), 32'h9);
    check("red", 32'(snd0_red), 32'h6);
    rcv0_req = 1'b0;
    wait_ack(1'b0, "frag_ack_lo");
    ack_en = 1'b1;
    drain();
    repeat (4) @(negedge i_clk);
    check("fifo_empty_after_pop", 32'(snd0_req), 32'd0);

    // 3: fill FIFO, stall 5th last fragment, release after first pop
    ack_en = 1'b0;
    for (int k = 1; k <= 4; k++) send_pkt(rand_pkt(RSZ'(k)));
    p = rand_pkt(RSZ'(5));
    exp_q.push_back(p);
    for (int i = 0; i < NFRG - 1; i++) send_frag(frag_of(p, i));
    @(negedge i_clk);
    rcv0_pakio = frag_of(p, NFRG - 1);
    rcv0_req   = 1'b1;
    repeat (5) begin
      @(negedge i_clk);
      check("stall_full", 32'(rcv0_ack), 32'd0);
    end
    check("held_red1", 32'(snd0_red), 32'd1);
    fast   = 1'b1;
    ack_en = 1'b1;
    n = 0;
    do begin
      @(negedge i_clk);
      #1;
      n++;
    end while (!(snd0_req && snd0_ack) && n < 50);
    check("consumer_ack_seen", 32'(snd0_req && snd0_ack), 32'd1);
    @(negedge i_clk);
    check("stall_at_pop_edge", 32'(rcv0_ack), 32'd0);
    @(negedge i_clk);
    check("stall_release", 32'(rcv0_ack), 32'd1);
    rcv0_req = 1'b0;
    wait_ack(1'b0, "frag_ack_lo");
    drain();

    // 4: 100 random back-to-back packets, immediate consumer
    for (int k = 0; k < 100; k++) send_pkt(rand_pkt(RSZ'($urandom)));
    drain();
    fast = 1'b0;
    for (int k = 0; k < 20; k++) send_pkt(rand_pkt(RSZ'($urandom)));
    drain();

    // 5: reset mid-packet, then fresh packet
    p = rand_pkt(RSZ'($urandom));
    send_frag(frag_of(p, 0));
    send_frag(frag_of(p, 1));
    do_reset(2);
    check("ready_after_midreset", 32'(ready), 32'd1);
    send_pkt(rand_pkt(RSZ'($urandom)));
    drain();
    repeat (5) @(negedge i_clk);
    check("no_stale", 32'(snd0_req), 32'd0);

    // 6: req raised during init cycle is ignored until ready
    @(negedge i_clk);
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge i_clk);
    p = rand_pkt(RSZ'($urandom));
    exp_q.push_back(p);
    reset      = 1'b0;
    rcv0_pakio = frag_of(p, 0);
    rcv0_req   = 1'b1;
    check("init_not_ready", 32'(ready), 32'd0);
    @(negedge i_clk);
    check("init_ready", 32'(ready), 32'd1);
    check("init_no_capture", 32'(rcv0_ack), 32'd0);
    @(negedge i_clk);
    check("init_then_capture", 32'(rcv0_ack), 32'd1);
    rcv0_req = 1'b0;
    wait_ack(1'b0, "frag_ack_lo");
    for (int i = 1; i < NFRG; i++) send_frag(frag_of(p, i));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
